// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window sequencer.
// Holds the state encoding, the bank-select width and the modulo-3 increment.
package sobel_pkg;

  localparam int BANK_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL0 = 2'd1,
    ST_FILL1 = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  function automatic logic [BANK_W-1:0] mod3_inc(input logic [BANK_W-1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

endpackage

// File: rtl/sobel_bank_rot.sv
// Modulo-3 rotation of the three row RAMs: which one is written, which holds y-1 and y-2.
// Bank outputs are registered per accepted beat and hold their value between beats.
module sobel_bank_rot
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              sof,
  input  logic              eol,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] mid_bank,
  output logic [BANK_W-1:0] top_bank
);

  logic [BANK_W-1:0] wb_q, wb_d;
  logic [BANK_W-1:0] eff_wb;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] mid_bank_q, mid_bank_d;
  logic [BANK_W-1:0] top_bank_q, top_bank_d;

  always_comb begin
    eff_wb     = sof ? '0 : wb_q;
    wb_d       = wb_q;
    wr_bank_d  = wr_bank_q;
    mid_bank_d = mid_bank_q;
    top_bank_d = top_bank_q;
    if (beat) begin
      // The line just finished becomes y-1 once the pointer moves on.
      wb_d       = eol ? mod3_inc(eff_wb) : eff_wb;
      wr_bank_d  = eff_wb;
      top_bank_d = mod3_inc(eff_wb);
      mid_bank_d = mod3_inc(mod3_inc(eff_wb));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      wr_bank_q  <= 2'd0;
      mid_bank_q <= 2'd2;
      top_bank_q <= 2'd1;
    end else begin
      wb_q       <= wb_d;
      wr_bank_q  <= wr_bank_d;
      mid_bank_q <= mid_bank_d;
      top_bank_q <= top_bank_d;
    end
  end

  assign wr_bank  = wr_bank_q;
  assign mid_bank = mid_bank_q;
  assign top_bank = top_bank_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster sequencer for the 3-line Sobel window: line-buffer address, bank selects, window qualifiers.
// All outputs registered (1 cycle after the beat); SOBEL_LEN_CHECK_EN enables the sticky line-length check.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int LINE_W = 640,
  parameter int ADDR_W = 10,
  parameter int LINE_H = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eol,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] mid_bank,
  output logic [BANK_W-1:0] top_bank,
  output logic              shift_en,
  output logic              win_valid,
  output logic              win_eol,
  output logic              win_eof,
  output logic              err_len
);

  localparam int Y_W = (LINE_H > 1) ? $clog2(LINE_H) : 1;
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(LINE_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(LINE_H - 1);

  state_t            state_q, state_d, eff_state;
  logic [ADDR_W-1:0] x_q, x_d, eff_x;
  logic [Y_W-1:0]    y_q, y_d, eff_y;
  logic              beat, win;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              win_valid_q, win_valid_d;
  logic              win_eol_q, win_eol_d;
  logic              win_eof_q, win_eof_d;

  // A start-of-frame beat restarts the raster before its own eol/column handling.
  always_comb begin
    beat        = in_valid && ((state_q != ST_IDLE) || in_sof);
    eff_state   = in_sof ? ST_FILL0 : state_q;
    eff_x       = in_sof ? '0 : x_q;
    eff_y       = in_sof ? '0 : y_q;
    win         = (eff_state == ST_RUN) && (eff_x >= ADDR_W'(2));
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    win_valid_d = 1'b0;
    win_eol_d   = 1'b0;
    win_eof_d   = 1'b0;
    if (beat) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = eff_x;
      win_valid_d = win;
      win_eol_d   = win && in_eol;
      win_eof_d   = win && in_eol && (eff_y == Y_LAST);
      if (in_eol) begin
        x_d = '0;
        if (eff_y == Y_LAST) begin
          state_d = ST_IDLE;
          y_d     = '0;
        end else begin
          y_d     = eff_y + 1'b1;
          state_d = (eff_state == ST_FILL0) ? ST_FILL1 : ST_RUN;
        end
      end else begin
        x_d     = (eff_x == X_LAST) ? eff_x : eff_x + 1'b1;
        y_d     = eff_y;
        state_d = eff_state;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      win_valid_q <= 1'b0;
      win_eol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      win_valid_q <= win_valid_d;
      win_eol_q   <= win_eol_d;
      win_eof_q   <= win_eof_d;
    end
  end

  sobel_bank_rot u_bank_rot (
    .clk      (clk),
    .rst      (rst),
    .beat     (beat),
    .sof      (in_sof),
    .eol      (in_eol),
    .wr_bank  (wr_bank),
    .mid_bank (mid_bank),
    .top_bank (top_bank)
  );

`ifdef SOBEL_LEN_CHECK_EN
  logic err_len_q, err_len_d;

  always_comb begin
    err_len_d = err_len_q;
    if (beat) begin
      if (in_sof) err_len_d = 1'b0;
      if (in_eol ? (eff_x != X_LAST) : (eff_x == X_LAST)) err_len_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_len_q <= 1'b0;
    else     err_len_q <= err_len_d;
  end

  assign err_len = err_len_q;
`else
  assign err_len = 1'b0;
`endif

  // Write and shift strobes describe the same beat.
  assign wr_en     = wr_en_q;
  assign shift_en  = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign win_valid = win_valid_q;
  assign win_eol   = win_eol_q;
  assign win_eof   = win_eof_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl with an 8x4 raster.
module tb_sobel_window_ctrl;

  localparam int LW = 8;
  localparam int LH = 4;
  localparam int AW = 10;
`ifdef SOBEL_LEN_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_sof, in_eol;
  logic          wr_en, shift_en, win_valid, win_eol, win_eof, err_len;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_bank, mid_bank, top_bank;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.LINE_W(LW), .ADDR_W(AW), .LINE_H(LH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .mid_bank(mid_bank),
    .top_bank(top_bank), .shift_en(shift_en), .win_valid(win_valid),
    .win_eol(win_eol), .win_eof(win_eof), .err_len(err_len)
  );

  typedef struct {
    logic          sof, eol;
    logic [AW-1:0] addr;
    logic [1:0]    bank, mid, top;
    logic          win, weol, weof;
  } vec_t;

  vec_t frame [32];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt_win, cnt_eol, cnt_eof;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic e);
    in_valid = v;
    in_sof   = s;
    in_eol   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input int i);
    cycle(1'b1, frame[i].sof, frame[i].eol);
    chk($sformatf("row%0d wr_en", i),     32'(wr_en),     32'd1);
    chk($sformatf("row%0d shift_en", i),  32'(shift_en),  32'd1);
    chk($sformatf("row%0d wr_addr", i),   32'(wr_addr),   32'(frame[i].addr));
    chk($sformatf("row%0d wr_bank", i),   32'(wr_bank),   32'(frame[i].bank));
    chk($sformatf("row%0d mid_bank", i),  32'(mid_bank),  32'(frame[i].mid));
    chk($sformatf("row%0d top_bank", i),  32'(top_bank),  32'(frame[i].top));
    chk($sformatf("row%0d win_valid", i), 32'(win_valid), 32'(frame[i].win));
    chk($sformatf("row%0d win_eol", i),   32'(win_eol),   32'(frame[i].weol));
    chk($sformatf("row%0d win_eof", i),   32'(win_eof),   32'(frame[i].weof));
    cnt_win += int'(win_valid);
    cnt_eol += int'(win_eol);
    cnt_eof += int'(win_eof);
  endtask

  task automatic clr_counts();
    cnt_win = 0;
    cnt_eol = 0;
    cnt_eof = 0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " win_valid count"}, 32'(cnt_win), 32'd12);
    chk({tag, " win_eol count"},   32'(cnt_eol), 32'd2);
    chk({tag, " win_eof count"},   32'(cnt_eof), 32'd1);
  endtask

  initial begin
    for (int l = 0; l < LH; l++) begin
      for (int c = 0; c < LW; c++) begin
        int i;
        i = l * LW + c;
        frame[i].sof  = (l == 0 && c == 0);
        frame[i].eol  = (c == LW - 1);
        frame[i].addr = AW'(c);
        frame[i].bank = 2'(l % 3);
        frame[i].mid  = 2'((l + 2) % 3);
        frame[i].top  = 2'((l + 1) % 3);
        frame[i].win  = (l >= 2) && (c >= 2);
        frame[i].weol = frame[i].win && (c == LW - 1);
        frame[i].weof = frame[i].weol && (l == LH - 1);
      end
    end

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset shift_en", 32'(shift_en), 32'd0);
    chk("reset win_valid", 32'(win_valid), 32'd0);
    chk("reset win_eol", 32'(win_eol), 32'd0);
    chk("reset win_eof", 32'(win_eof), 32'd0);
    chk("reset err_len", 32'(err_len), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset wr_bank", 32'(wr_bank), 32'd0);
    chk("reset mid_bank", 32'(mid_bank), 32'd2);
    chk("reset top_bank", 32'(top_bank), 32'd1);
    rst = 1'b0;

    // Beats without sof are dropped
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, (k == 2));
      chk("idle drop wr_en", 32'(wr_en), 32'd0);
      chk("idle drop shift_en", 32'(shift_en), 32'd0);
    end

    // Contiguous frame
    clr_counts();
    for (int i = 0; i < 32; i++) apply_row(i);
    chk_counts("contig");
    cycle(1'b1, 1'b0, 1'b0);
    chk("post-eof drop wr_en", 32'(wr_en), 32'd0);

    // Frame with random gaps; sof/eol toggle while in_valid is low
    clr_counts();
    for (int i = 0; i < 32; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("gap wr_en", 32'(wr_en), 32'd0);
        chk("gap shift_en", 32'(shift_en), 32'd0);
        chk("gap win_valid", 32'(win_valid), 32'd0);
      end
      apply_row(i);
    end
    chk_counts("gaps");

    // sof mid-line at y=2, x=5 restarts the frame
    for (int i = 0; i <= 20; i++) apply_row(i);
    clr_counts();
    for (int i = 0; i < 32; i++) apply_row(i);
    chk_counts("midline sof");

    // sof and eol on the same beat
    cycle(1'b1, 1'b1, 1'b1);
    chk("sof+eol wr_addr", 32'(wr_addr), 32'd0);
    chk("sof+eol wr_bank", 32'(wr_bank), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("after sof+eol wr_bank", 32'(wr_bank), 32'd1);
    chk("after sof+eol wr_addr", 32'(wr_addr), 32'd0);
    chk("after sof+eol mid_bank", 32'(mid_bank), 32'd0);
    chk("after sof+eol top_bank", 32'(top_bank), 32'd2);
    chk("after sof+eol win_valid", 32'(win_valid), 32'd0);
    for (int c = 1; c < LW; c++) cycle(1'b1, 1'b0, (c == LW - 1));
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("line2 x1 win_valid", 32'(win_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("line2 x2 win_valid", 32'(win_valid), 32'd1);
    chk("line2 x2 wr_bank", 32'(wr_bank), 32'd2);

    // Reset mid-frame, with a beat present during reset
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    chk("midrst wr_en", 32'(wr_en), 32'd0);
    chk("midrst wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst wr_bank", 32'(wr_bank), 32'd0);
    chk("midrst mid_bank", 32'(mid_bank), 32'd2);
    chk("midrst top_bank", 32'(top_bank), 32'd1);
    chk("midrst win_valid", 32'(win_valid), 32'd0);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    chk("post-rst drop wr_en", 32'(wr_en), 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("post-rst drop eol wr_en", 32'(wr_en), 32'd0);

    // Line-length check, short line then a correct one
    cycle(1'b1, 1'b1, 1'b0);
    chk("len sof err_len", 32'(err_len), 32'd0);
    for (int c = 1; c < 5; c++) cycle(1'b1, 1'b0, 1'b0);
    chk("len pre-eol err_len", 32'(err_len), 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("len short eol err_len", 32'(err_len), 32'(ERR_ON));
    chk("len short eol wr_addr", 32'(wr_addr), 32'd5);
    for (int c = 0; c < LW; c++) cycle(1'b1, 1'b0, (c == LW - 1));
    chk("len good line err_len", 32'(err_len), 32'(ERR_ON));

    // Column saturation on an over-long line
    for (int c = 0; c < LW; c++) cycle(1'b1, 1'b0, 1'b0);
    chk("sat x7 wr_addr", 32'(wr_addr), 32'd7);
    cycle(1'b1, 1'b0, 1'b0);
    chk("sat x8 wr_addr", 32'(wr_addr), 32'd7);
    cycle(1'b1, 1'b0, 1'b1);
    chk("sat eol wr_addr", 32'(wr_addr), 32'd7);
    chk("sat eol err_len", 32'(err_len), 32'(ERR_ON));

    cycle(1'b1, 1'b1, 1'b0);
    chk("len sof clear err_len", 32'(err_len), 32'd0);
    chk("len sof clear wr_addr", 32'(wr_addr), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Sequencer for the 3-line Sobel window datapath. It tracks the incoming pixel raster and generates the line-buffer write address, the rotating bank selects for the three row RAMs, and the column shift-register enable. It qualifies the output with window-valid and line/frame markers, so the edge stage only consumes windows whose 3×3 neighbourhood is fully populated. It sits between the camera pixel stream and the line-buffer/shift-register/gradient datapath.

## Interface
Parameters:
- `LINE_W`, 640: active pixels per line.
- `ADDR_W`, 10: line-buffer address width; requires `2**ADDR_W >= LINE_W`.
- `LINE_H`, 480: active lines per frame.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  pixel beat present this cycle.
- `in_sof`  in  1  first pixel of frame; qualified by `in_valid`.
- `in_eol`  in  1  last pixel of line; qualified by `in_valid`.
- `wr_en`  out  1  line-buffer write strobe for the current beat.
- `wr_addr`  out  ADDR_W  line-buffer column address for the current beat.
- `wr_bank`  out  2  RAM index (0..2) receiving the incoming line.
- `mid_bank`  out  2  RAM holding line y-1.
- `top_bank`  out  2  RAM holding line y-2.
- `shift_en`  out  1  advance the three column shift registers.
- `win_valid`  out  1  the 3×3 window in the shift registers is complete.
- `win_eol`  out  1  last valid window of a line.
- `win_eof`  out  1  last valid window of a frame.
- `err_len`  out  1  sticky line-length error (see Configuration).

## Operation
- Registers: column counter `x` (0..LINE_W-1), line counter `y` (0..LINE_H-1), bank pointer `wb` (0..2, modulo 3), state.
- States:
  - IDLE: wait for a beat with `in_sof`.
  - FILL0 (y=0).
  - FILL1 (y=1).
  - RUN (y≥2).
- Transitions:
  - A beat with `in_sof` in any state forces x=0, y=0, wb=0, state FILL0, and the beat is written.
  - A beat with `in_eol` sets x=0, y=y+1 and wb=(wb+1) mod 3. The state advances FILL0→FILL1→RUN and stays in RUN.
  - An `in_eol` beat with y=LINE_H-1 returns to IDLE.
  - Any other beat sets x=x+1, saturating at LINE_W-1.
- Outputs per accepted beat (in_valid=1, state≠IDLE or in_sof=1):
  - `wr_en`=1, `shift_en`=1, `wr_addr`=x, `wr_bank`=wb.
  - `mid_bank`=(wb+2) mod 3, `top_bank`=(wb+1) mod 3.
- `win_valid`=1 when state=RUN and x≥2. The window is centred on column x-1, line y-1.
- `win_eol`=win_valid and beat is `in_eol`.
- `win_eof`=win_eol and y=LINE_H-1.
- Beats while IDLE without `in_sof` are dropped: all strobes stay 0.
- Bank selects are defined every cycle, including cycles with no beat.

## Timing
- Reset values:
  - All strobes and `err_len` = 0.
  - `wr_addr`=0, `wr_bank`=0, `mid_bank`=2, `top_bank`=1.
  - State IDLE, x=y=wb=0.
- Strobes and the address/bank outputs are registered: they appear 1 cycle after the input beat that causes them. The datapath must delay pixel data by 1 register to match.
- `win_valid` is asserted in the same cycle as the `shift_en` that loads the window's rightmost column. Gradient latency downstream is not this block's concern.
- `in_sof` and `in_eol` on the same beat: `in_sof` handling applies first, then `in_eol` handling, giving y=1, wb=1, state FILL1.
- `rst` asserted mid-frame: outputs return to reset values on the next edge, and all later beats are dropped until the next `in_sof`.
- Stalls (in_valid=0) freeze all counters; the output strobes are 0 during stalls.

## Configuration
- `SOBEL_LEN_CHECK_EN` defined:
  - `err_len` is set when an `in_eol` beat arrives with x≠LINE_W-1, or when a non-eol beat arrives with x=LINE_W-1.
  - `err_len` is cleared only by `rst` or by an `in_sof` beat.
- Not defined: `err_len` is tied to 0 and the check logic is absent.

## Structure
- Shared package `sobel_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_FILL0`, `ST_FILL1`, `ST_RUN`);
  - the `BANK_W`=2 constant;
  - a `mod3_inc` function.
- One sub-module, `sobel_bank_rot`: the modulo-3 bank pointer and the derivation of `mid_bank`/`top_bank`.

## Test plan
All tests use LINE_W=8, LINE_H=4.
- Reset: hold `rst` for 2 cycles. Expect all strobes 0, `mid_bank`=2, `top_bank`=1. Beats sent without `in_sof` then produce no `wr_en`.
- Full frame of 32 contiguous beats:
  - `wr_addr` cycles 0..7 on each line;
  - `wr_bank` goes 0,1,2,0 across the four lines;
  - `win_valid` count = 2 lines × 6 = 12;
  - `win_eol` fires twice;
  - `win_eof` fires once, on the final beat's output.
- Random `in_valid` gaps: counts and ordering are identical to the contiguous case, and strobes are 0 in every gap cycle.
- `in_sof` mid-line at y=2, x=5: the next output has `wr_addr`=0, `wr_bank`=0, state FILL0, and there is no `win_valid` until line 2 of the new frame.
- Simultaneous `in_sof`+`in_eol`: the following beat has `wr_bank`=1 and `wr_addr`=0.
- With `SOBEL_LEN_CHECK_EN`:
  - `in_eol` at x=5 sets `err_len`=1 one cycle later;
  - `err_len` stays 1 through the next correct line;
  - `err_len` clears on the next `in_sof`.
  - Without the macro, `err_len` is always 0.
